// File: rtl/gfx_ctrl_pkg.sv
// Shared types and defaults for the graphics control blocks in the clk_render domain.
// Frame sequencer state encoding is exported so debug tooling can decode state_o.
package gfx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWAP   = 3'd1,
        ST_START  = 3'd2,
        ST_ARM    = 3'd3,
        ST_RENDER = 3'd4
    } frame_seq_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4_000_000;
    localparam int DEFAULT_ARM_CYCLES     = 4;
    localparam int DEFAULT_CNT_W          = 16;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for a slow level/pulse from another clock domain,
// followed by a rising-edge detector that yields a single-cycle strobe.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // sync2_d is a plain delay of the already-safe sync2 level, used only for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= async_in;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: turns a pixel-domain frame pulse into swap/begin strobes,
// tracks renderer completion, drops overlapping frames and aborts hung renders.
module frame_sequencer
    import gfx_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ARM_CYCLES     = DEFAULT_ARM_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic             clk_render,
    input  logic             btn_rst_n,
    input  logic             frame_pix,
    input  logic             enable,
    input  logic             render_busy,
    output logic             fb_swap,
    output logic             begin_frame,
    output logic             render_abort,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [2:0]       state_o
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ARM_W = $clog2(ARM_CYCLES + 1);

    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    frame_seq_state_e state;
    frame_seq_state_e next_state;

    logic             frame_edge;
    logic [ARM_W-1:0] arm_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             arm_clr;
    logic             arm_inc;
    logic             wd_clr;
    logic             wd_inc;
    logic             frame_done;
    logic             frame_drop;

    pulse_sync_edge u_frame_sync (
        .clk      (clk_render),
        .rst_n    (btn_rst_n),
        .async_in (frame_pix),
        .rise     (frame_edge)
    );

    always_ff @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are decoded from state so a reset mid-frame kills them immediately
    always_comb begin
        next_state   = state;
        fb_swap      = 1'b0;
        begin_frame  = 1'b0;
        render_abort = 1'b0;
        arm_clr      = 1'b0;
        arm_inc      = 1'b0;
        wd_clr       = 1'b0;
        wd_inc       = 1'b0;
        frame_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_edge && enable) begin
                    next_state = ST_SWAP;
                end
            end
            ST_SWAP: begin
                fb_swap    = 1'b1;
                next_state = ST_START;
            end
            ST_START: begin
                begin_frame = 1'b1;
                arm_clr     = 1'b1;
                next_state  = ST_ARM;
            end
            ST_ARM: begin
                if (render_busy) begin
                    wd_clr     = 1'b1;
                    next_state = ST_RENDER;
                end else if (arm_cnt == ARM_LAST) begin
                    frame_done = 1'b1;
                    next_state = ST_IDLE;
                end else begin
                    arm_inc = 1'b1;
                end
            end
            ST_RENDER: begin
                // Completion wins over the watchdog when both land on the same cycle
                if (!render_busy) begin
                    frame_done = 1'b1;
                    next_state = ST_IDLE;
                end else if (wd_cnt == WD_LIMIT) begin
                    render_abort = 1'b1;
                    next_state   = ST_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign frame_drop = frame_edge && (state != ST_IDLE);

    always_ff @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            arm_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            if (arm_clr) begin
                arm_cnt <= '0;
            end else if (arm_inc) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            if (wd_clr) begin
                wd_cnt <= '0;
            end else if (wd_inc) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // frame_count wraps; drop and timeout counters stick at all-ones
    always_ff @(posedge clk_render or negedge btn_rst_n) begin
        if (!btn_rst_n) begin
            frame_count   <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 1'b1;
            end
            if (frame_drop && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (render_abort && (timeout_count != CNT_MAX)) begin
                timeout_count <= timeout_count + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule
